// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// pipeline_pkg : shared helpers and types for the elastic pipeline controller
// Revision     : 1.0
// ============================================================================
package pipeline_pkg;

  // Occupancy counter width: must represent 0..n inclusive.
  function automatic int count_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2,
    CNT_CLR  = 2'd3
  } cnt_op_e;

endpackage
`default_nettype wire

// File: rtl/pipeline_if.sv
`default_nettype none
// ============================================================================
// pipeline_if : producer/consumer valid-ready handshake around the pipeline
// Revision    : 1.0
// ============================================================================
interface pipeline_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/pipeline_stage.sv
`default_nettype none
// ============================================================================
// pipeline_stage : one data register plus valid bit of the elastic pipeline
// Revision       : 1.0
// ============================================================================
module pipeline_stage #(
  parameter int DW = 32
) (
  input  wire logic          clk,
  input  wire logic          nreset,
  input  wire logic          load,
  input  wire logic          in_valid,
  input  wire logic [DW-1:0] in_data,
  output logic               valid,
  output logic [DW-1:0]      data
);

  logic          r_valid;
  logic [DW-1:0] r_data;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_valid <= 1'b0;
    end else if (load) begin
      r_valid <= in_valid;
    end
  end

  // Data is left unreset and only captured with a valid item to avoid toggling.
  always_ff @(posedge clk) begin
    if (load && in_valid) begin
      r_data <= in_data;
    end
  end

  assign valid = r_valid;
  assign data  = r_data;

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_ctrl : elastic valid/ready controller over an N-stage delay line
// Revision      : 1.0
// ============================================================================
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter  int DW = 32,
  parameter  int N  = 8,
  localparam int CW = count_width(N)
) (
  input  wire logic    clk,
  input  wire logic    nreset,
  input  wire logic    flush,
  pipeline_if.slave    bus,
  output logic [CW-1:0] count,
  output logic          busy
);

  localparam logic [CW-1:0] c_cnt_one = CW'(1);

  logic [N:0]    w_rdy;
  logic [N-1:0]  w_valid;
  logic [DW-1:0] w_data [N];
  logic          w_in_acc;
  logic          w_out_acc;
  cnt_op_e       w_cnt_op;
  logic [CW-1:0] r_count;

  // Ready ripples back from the consumer; an empty stage is always ready.
  always_comb begin
    w_rdy    = '0;
    w_rdy[N] = bus.out_ready;
    for (int i = N - 1; i >= 0; i--) begin
      w_rdy[i] = ~w_valid[i] | w_rdy[i+1];
    end
  end

  assign bus.in_ready  = w_rdy[0] & ~flush;
  assign bus.out_valid = w_valid[N-1];
  assign bus.out_data  = w_data[N-1];

  assign w_in_acc  = bus.in_valid & bus.in_ready;
  assign w_out_acc = bus.out_valid & bus.out_ready;

  generate
    for (genvar i = 0; i < N; i++) begin : g_stage
      logic          w_stage_vin;
      logic [DW-1:0] w_stage_din;

      if (i == 0) begin : g_head
        assign w_stage_vin = w_in_acc;
        assign w_stage_din = bus.in_data;
      end else begin : g_body
        assign w_stage_vin = w_valid[i-1];
        assign w_stage_din = w_data[i-1];
      end

      // Flush forces every stage to load an empty slot.
      pipeline_stage #(
        .DW (DW)
      ) u_stage (
        .clk      (clk),
        .nreset   (nreset),
        .load     (w_rdy[i] | flush),
        .in_valid (w_stage_vin & ~flush),
        .in_data  (w_stage_din),
        .valid    (w_valid[i]),
        .data     (w_data[i])
      );
    end
  endgenerate

  always_comb begin
    w_cnt_op = CNT_HOLD;
    if (flush) begin
      w_cnt_op = CNT_CLR;
    end else if (w_in_acc && !w_out_acc) begin
      w_cnt_op = CNT_INC;
    end else if (w_out_acc && !w_in_acc) begin
      w_cnt_op = CNT_DEC;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_count <= '0;
    end else begin
      case (w_cnt_op)
        CNT_INC:  r_count <= r_count + c_cnt_one;
        CNT_DEC:  r_count <= r_count - c_cnt_one;
        CNT_CLR:  r_count <= '0;
        default:  r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;
  assign busy  = (r_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipeline_ctrl : scoreboard bench for pipeline_ctrl (DW=8, N=4)
// Revision         : 1.0
// ============================================================================
module tb_pipeline_ctrl;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int CW = 3;

  logic          clk    = 1'b0;
  logic          nreset = 1'b0;
  logic          flush  = 1'b0;
  logic [CW-1:0] count;
  logic          busy;

  pipeline_if #(.DW(DW)) bus ();

  pipeline_ctrl #(
    .DW (DW),
    .N  (N)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .flush  (flush),
    .bus    (bus),
    .count  (count),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  int            total = 0;
  int            bad   = 0;
  int            edges = 0;
  int            m_occ = 0;
  int            n_out = 0;
  logic [DW-1:0] sb[$];

  always @(posedge clk) edges <= edges + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Monitor: reference model of occupancy/ready plus in-order scoreboard.
  initial begin
    forever begin
      logic          ia;
      logic          oa;
      logic [DW-1:0] exp_d;
      @(negedge clk);
      #2;
      if (nreset) begin
        check("count", int'(count), m_occ);
        check("busy", int'(busy), int'(m_occ != 0));
        check("in_ready", int'(bus.in_ready),
              int'(!flush && (m_occ < N || bus.out_ready)));
        if (m_occ == 0) check("idle_out_valid", int'(bus.out_valid), 0);
        ia = bus.in_valid && bus.in_ready;
        oa = bus.out_valid && bus.out_ready;
        if (oa) begin
          if (sb.size() == 0) begin
            check("unexpected_out", 1, 0);
          end else begin
            exp_d = sb.pop_front();
            check("out_data", int'(bus.out_data), int'(exp_d));
            n_out++;
          end
        end
        if (flush) begin
          m_occ = 0;
          sb.delete();
        end else begin
          m_occ = m_occ + int'(ia) - int'(oa);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic ordy,
                       input logic fl, output logic acc);
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = ordy;
    flush         = fl;
    #1;
    acc = v && bus.in_ready;
    if (acc) sb.push_back(d);
  endtask

  task automatic drain(input string name);
    logic acc;
    for (int c = 0; c < 40 && sb.size() != 0; c++) drive(1'b0, '0, 1'b1, 1'b0, acc);
    drive(1'b0, '0, 1'b1, 1'b0, acc);
    #2;
    check(name, sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   acc_edge;
    int   ov_edge;
    int   base;
    int   idx;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;

    // Reset state
    @(negedge clk);
    #2;
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_count", int'(count), 0);
    check("rst_busy", int'(busy), 0);
    @(negedge clk);
    #3 nreset = 1'b1;

    // 1: continuous stream with free-running consumer
    acc_edge = -1;
    ov_edge  = -1;
    base     = n_out;
    for (int i = 0; i < 24; i++) begin
      drive(i < 16, DW'(i + 1), 1'b1, 1'b0, acc);
      if (acc && acc_edge < 0) acc_edge = edges + 1;
      if (bus.out_valid && ov_edge < 0) ov_edge = edges;
      if (i >= 4 && i <= 16) check("t1_count_steady", int'(count), 4);
    end
    #2;
    check("t1_latency", ov_edge - acc_edge, 3);
    check("t1_delivered", n_out - base, 16);

    // 2: stalled consumer, six offered items
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      drive(idx < 6, DW'(idx + 1), 1'b0, 1'b0, acc);
      if (acc) idx++;
    end
    check("t2_accepted", idx, 4);
    check("t2_in_ready", int'(bus.in_ready), 0);
    check("t2_count", int'(count), 4);
    check("t2_out_valid", int'(bus.out_valid), 1);
    check("t2_out_data", int'(bus.out_data), 1);
    base = n_out;
    for (int c = 0; c < 20; c++) begin
      drive(idx < 6, DW'(idx + 1), 1'b1, 1'b0, acc);
      if (acc) idx++;
    end
    #2;
    check("t2_delivered", n_out - base, 6);

    // 3: bubble collapse while stalled
    drive(1'b1, 8'hA1, 1'b0, 1'b0, acc);
    check("t3_acc_a1", int'(acc), 1);
    drive(1'b0, '0, 1'b0, 1'b0, acc);
    drive(1'b0, '0, 1'b0, 1'b0, acc);
    drive(1'b1, 8'hA2, 1'b0, 1'b0, acc);
    check("t3_acc_a2", int'(acc), 1);
    for (int c = 0; c < 3; c++) drive(1'b0, '0, 1'b0, 1'b0, acc);
    check("t3_count", int'(count), 2);
    drive(1'b0, '0, 1'b1, 1'b0, acc);
    check("t3_first_valid", int'(bus.out_valid), 1);
    drive(1'b0, '0, 1'b1, 1'b0, acc);
    check("t3_back_to_back", int'(bus.out_valid), 1);
    drive(1'b0, '0, 1'b1, 1'b0, acc);
    check("t3_empty_after", int'(bus.out_valid), 0);

    // 4: full pipe with simultaneous in/out transfers
    for (int i = 0; i < 4; i++) drive(1'b1, DW'(8'hB0 + i), 1'b0, 1'b0, acc);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DW'(8'hC0 + i), 1'b1, 1'b0, acc);
      check("t4_in_ready", int'(bus.in_ready), 1);
      check("t4_count", int'(count), 4);
    end
    drain("t4_drain");

    // 5: flush with count=3
    for (int i = 0; i < 3; i++) drive(1'b1, DW'(8'hD0 + i), 1'b0, 1'b0, acc);
    drive(1'b0, '0, 1'b0, 1'b0, acc);
    check("t5_count_pre", int'(count), 3);
    drive(1'b1, 8'hEE, 1'b0, 1'b1, acc);
    check("t5_in_ready_flush", int'(bus.in_ready), 0);
    drive(1'b0, '0, 1'b0, 1'b0, acc);
    check("t5_out_valid", int'(bus.out_valid), 0);
    check("t5_count", int'(count), 0);
    check("t5_busy", int'(busy), 0);
    for (int i = 0; i < 3; i++) drive(1'b1, DW'(8'hE0 + i), 1'b1, 1'b0, acc);
    drain("t5_drain");

    // 6: asynchronous reset mid-stream
    for (int i = 0; i < 2; i++) drive(1'b1, DW'(8'hF0 + i), 1'b0, 1'b0, acc);
    drive(1'b0, '0, 1'b0, 1'b0, acc);
    check("t6_count_pre", int'(count), 2);
    @(negedge clk);
    #4 nreset = 1'b0;
    #1;
    check("t6_out_valid", int'(bus.out_valid), 0);
    check("t6_count", int'(count), 0);
    check("t6_busy", int'(busy), 0);
    sb.delete();
    m_occ = 0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #3 nreset = 1'b1;
    drive(1'b1, 8'h5A, 1'b1, 1'b0, acc);
    acc_edge = acc ? edges + 1 : -100;
    ov_edge  = -1;
    for (int c = 0; c < 10 && ov_edge < 0; c++) begin
      drive(1'b0, '0, 1'b1, 1'b0, acc);
      if (bus.out_valid) ov_edge = edges;
    end
    check("t6_latency", ov_edge - acc_edge, 3);

    // Randomized traffic with occasional flush
    for (int c = 0; c < 600; c++) begin
      drive($urandom_range(0, 9) < 7, DW'($urandom), $urandom_range(0, 9) < 6,
            $urandom_range(0, 49) == 0, acc);
    end
    drain("final_drain");
    check("final_count", int'(count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
